uart_rx_byte: RTL and testbench

//  8N1 UART receiver; downstream consumer of uart_tx serial output (loopback/link partner).

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_sync_2ff.sv | 25 ++
 rtl/uart_rx_byte.sv | 155 +++++++++++++++
 tb/tb_uart_rx_byte.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings (common with uart_tx) and counter width.
package uart_pkg;

  localparam int unsigned CLK_CNT_W = 14;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] START   = 3'd1;
  localparam logic [2:0] DATA    = 3'd2;
  localparam logic [2:0] STOP    = 3'd3;
  localparam logic [2:0] CLEANUP = 3'd4;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input; reset value is configurable.
module uart_sync_2ff #(
  parameter logic ResetVal = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q, sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= ResetVal;
      sync_q <= ResetVal;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver with mid-bit sampling, 1-cycle DV / frame-error strobes.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around each sample point.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 10416
) (
  input  logic       i_Clock,
  input  logic       i_Rst_n,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Active,
  output logic       o_Rx_Frame_Err
);

  localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
  localparam logic [CLK_CNT_W-1:0] HalfLast = CLK_CNT_W'(HALF_BIT - 1);
  localparam logic [CLK_CNT_W-1:0] BitLast  = CLK_CNT_W'(CLKS_PER_BIT - 1);

  logic                 rx_s, rx_d_q;
  logic                 line, line_prev, bit_smp;
  logic [2:0]           state_q, state_d;
  logic [CLK_CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]           idx_q, idx_d;
  logic [7:0]           shift_q, shift_d;
  logic [7:0]           byte_q, byte_d;
  logic                 dv_q, dv_d;
  logic                 err_q, err_d;
  logic                 active_q, active_d;

  uart_sync_2ff #(
    .ResetVal(1'b1)
  ) u_sync (
    .clk_i (i_Clock),
    .rst_ni(i_Rst_n),
    .d_i   (i_Rx_Serial),
    .q_o   (rx_s)
  );

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) rx_d_q <= 1'b1;
    else          rx_d_q <= rx_s;
  end

`ifdef UART_RX_MAJORITY_EN
  // FSM runs on rx_s delayed one cycle, so at its sample point rx_s is already point+1.
  logic rx_dd_q;

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) rx_dd_q <= 1'b1;
    else          rx_dd_q <= rx_d_q;
  end

  assign line      = rx_d_q;
  assign line_prev = rx_dd_q;
  assign bit_smp   = maj3(rx_dd_q, rx_d_q, rx_s);
`else
  assign line      = rx_s;
  assign line_prev = rx_d_q;
  assign bit_smp   = rx_s;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    byte_d   = byte_q;
    dv_d     = 1'b0;
    err_d    = 1'b0;
    active_d = active_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        // Only a falling edge starts a frame; a line stuck low never re-triggers.
        if (line_prev && !line) state_d = START;
      end
      START: begin
        if (cnt_q == HalfLast) begin
          cnt_d = '0;
          if (!bit_smp) begin
            state_d  = DATA;
            active_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CLK_CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == BitLast) begin
          cnt_d          = '0;
          shift_d[idx_q] = bit_smp;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q + CLK_CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_q == BitLast) begin
          cnt_d    = '0;
          active_d = 1'b0;
          state_d  = CLEANUP;
          if (bit_smp) begin
            byte_d = shift_q;
            dv_d   = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CLK_CNT_W'(1);
        end
      end
      CLEANUP: state_d = IDLE;
      default: begin
        state_d  = IDLE;
        cnt_d    = '0;
        idx_d    = '0;
        active_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      byte_q   <= '0;
      dv_q     <= 1'b0;
      err_q    <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      byte_q   <= byte_d;
      dv_q     <= dv_d;
      err_q    <= err_d;
      active_q <= active_d;
    end
  end

  assign o_Rx_DV        = dv_q;
  assign o_Rx_Byte      = byte_q;
  assign o_Rx_Active    = active_q;
  assign o_Rx_Frame_Err = err_q;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte at CLKS_PER_BIT=8; serial line driven bit-by-bit from tasks.
module tb_uart_rx_byte;

  localparam int unsigned CPB = 8;
`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif

  logic       clk, rst_n, rx_line;
  logic       dv, active, ferr;
  logic [7:0] rx_byte;

  int   n_chk, n_fail;
  int   dv_cnt, err_cnt, act_cycles, wide_cnt, both_cnt;
  logic dv_prev, err_prev;
  logic [7:0] rx_log[$];
  time  t_dv, t_frame;

  uart_rx_byte #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .i_Clock       (clk),
    .i_Rst_n       (rst_n),
    .i_Rx_Serial   (rx_line),
    .o_Rx_DV       (dv),
    .o_Rx_Byte     (rx_byte),
    .o_Rx_Active   (active),
    .o_Rx_Frame_Err(ferr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Strobe monitor, sampled on the inactive edge.
  initial begin
    dv_cnt = 0; err_cnt = 0; act_cycles = 0; wide_cnt = 0; both_cnt = 0;
    dv_prev = 1'b0; err_prev = 1'b0; t_dv = 0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (dv) begin
          dv_cnt++;
          rx_log.push_back(rx_byte);
          t_dv = $time;
        end
        if (ferr) err_cnt++;
        if (active) act_cycles++;
        if ((dv && dv_prev) || (ferr && err_prev)) wide_cnt++;
        if (dv && ferr) both_cnt++;
      end
      dv_prev  = dv;
      err_prev = ferr;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives `len` cycles of an 8N1 frame; cycle `glitch` is inverted (-1 for none).
  task automatic send_frame(input logic [7:0] b, input logic stop_b, input int glitch,
                            input int len);
    logic v;
    t_frame = $time;
    for (int j = 0; j < len; j++) begin
      if (j < 8) v = 1'b0;
      else if (j < 72) v = b[(j - 8) / 8];
      else v = stop_b;
      if (j == glitch) v = ~v;
      rx_line = v;
      @(negedge clk);
    end
  endtask

  int dv0, err0, act0, log0;

  initial begin
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0; rx_line = 1'b1;
    idle(3);
    chk("rst_dv", 32'(dv), 32'h0);
    chk("rst_byte", 32'(rx_byte), 32'h0);
    chk("rst_active", 32'(active), 32'h0);
    chk("rst_ferr", 32'(ferr), 32'h0);
    rst_n = 1'b1;
    idle(40);
    chk("post_rst_no_start", 32'(dv_cnt + err_cnt + act_cycles), 32'h0);

    // Single good frame
    dv0 = dv_cnt; err0 = err_cnt; act0 = act_cycles; log0 = rx_log.size();
    send_frame(8'hA5, 1'b1, -1, 80);
    idle(10);
    chk("a5_dv_count", 32'(dv_cnt - dv0), 32'd1);
    chk("a5_byte", 32'(rx_byte), 32'hA5);
    chk("a5_log", 32'(rx_log[log0]), 32'hA5);
    chk("a5_no_ferr", 32'(err_cnt - err0), 32'd0);
    chk("a5_active_low", 32'(active), 32'h0);
    chk("a5_active_len", 32'(act_cycles - act0), 32'(72));
    chk("a5_latency", 32'(int'(t_dv - t_frame)), 32'((79 + MAJ) * 10));

    // Stop bit 0, then line held low as a break
    dv0 = dv_cnt; err0 = err_cnt;
    send_frame(8'h3C, 1'b0, -1, 80);
    idle(2);
    chk("fe_err_count", 32'(err_cnt - err0), 32'd1);
    chk("fe_no_dv", 32'(dv_cnt - dv0), 32'd0);
    chk("fe_byte_kept", 32'(rx_byte), 32'hA5);
    act0 = act_cycles;
    rx_line = 1'b0;
    idle(3 * CPB);
    chk("break_no_frame", 32'(dv_cnt - dv0 + err_cnt - err0 - 1), 32'd0);
    chk("break_no_active", 32'(act_cycles - act0), 32'd0);
    rx_line = 1'b1;
    idle(10);
    log0 = rx_log.size();
    send_frame(8'hC3, 1'b1, -1, 80);
    idle(10);
    chk("after_break_dv", 32'(dv_cnt - dv0), 32'd1);
    chk("after_break_byte", 32'(rx_log[log0]), 32'hC3);

    // Back-to-back frames with no idle gap
    dv0 = dv_cnt; log0 = rx_log.size();
    send_frame(8'h00, 1'b1, -1, 80);
    send_frame(8'hFF, 1'b1, -1, 80);
    send_frame(8'h55, 1'b1, -1, 80);
    rx_line = 1'b1;
    idle(10);
    chk("b2b_dv_count", 32'(dv_cnt - dv0), 32'd3);
    chk("b2b_byte0", 32'(rx_log[log0]), 32'h00);
    chk("b2b_byte1", 32'(rx_log[log0 + 1]), 32'hFF);
    chk("b2b_byte2", 32'(rx_log[log0 + 2]), 32'h55);

    // Two-cycle low glitch on an idle line
    dv0 = dv_cnt; err0 = err_cnt; act0 = act_cycles;
    send_frame(8'hFF, 1'b1, -1, 2);
    rx_line = 1'b1;
    idle(100);
    chk("glitch_no_dv", 32'(dv_cnt - dv0), 32'd0);
    chk("glitch_no_err", 32'(err_cnt - err0), 32'd0);
    chk("glitch_no_active", 32'(act_cycles - act0), 32'd0);

    // Reset in the middle of data bit 4
    dv0 = dv_cnt; err0 = err_cnt;
    send_frame(8'h81, 1'b1, -1, 44);
    chk("midframe_active", 32'(active), 32'h1);
    rst_n = 1'b0;
    idle(1);
    chk("midrst_outputs", 32'({dv, ferr, active, rx_byte}), 32'h0);
    idle(2);
    rx_line = 1'b1;
    rst_n = 1'b1;
    idle(100);
    chk("midrst_no_strobe", 32'(dv_cnt - dv0 + err_cnt - err0), 32'd0);
    chk("midrst_byte_zero", 32'(rx_byte), 32'h0);
    log0 = rx_log.size();
    send_frame(8'h81, 1'b1, -1, 80);
    idle(10);
    chk("post_rst_dv", 32'(dv_cnt - dv0), 32'd1);
    chk("post_rst_byte", 32'(rx_log[log0]), 32'h81);

    // Single-cycle inverted glitch at the centre of data bit 2
    dv0 = dv_cnt; log0 = rx_log.size();
    send_frame(8'hF0, 1'b1, 8 + 2 * 8 + 4, 80);
    idle(10);
    chk("mid_glitch_dv", 32'(dv_cnt - dv0), 32'd1);
    chk("mid_glitch_byte", 32'(rx_log[log0]), (MAJ == 1) ? 32'hF0 : 32'hF4);

    chk("strobe_width_1", 32'(wide_cnt), 32'd0);
    chk("dv_err_exclusive", 32'(both_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
